// File: rtl/vic_raster_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vic_raster_gen
//  Description : Raster timing and colour output stage for the VIC-II video
//                path on the HDMI pixel clock. Generates sync/display-enable,
//                pixel position counters, border/background/pixel colour via
//                the fixed C64 palette, raster-compare IRQ and test patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module vic_raster_gen #(
  parameter int POS_W    = 10,
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 12,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 68,
  parameter int V_ACTIVE = 576,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 39,
  parameter int SYNC_POL = 0,
  parameter int WIN_X0   = 40,
  parameter int WIN_X1   = 680,
  parameter int WIN_Y0   = 88,
  parameter int WIN_Y1   = 488
) (
  input  logic             clkHDMI,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [3:0]       border_col,
  input  logic [3:0]       bg_col,
  input  logic [3:0]       pixel_col_in,
  input  logic             pix_valid,
  input  logic [POS_W-1:0] raster_cmp,
  input  logic             irq_ack,
  output logic [POS_W-1:0] o_hpos,
  output logic [POS_W-1:0] o_vpos,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_display_on,
  output logic [3:0]       o_red,
  output logic [3:0]       o_green,
  output logic [3:0]       o_blue,
  output logic             o_frame_start,
  output logic             o_irq
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] c_H_LAST = POS_W'(c_H_TOTAL - 1);
  localparam logic [POS_W-1:0] c_V_LAST = POS_W'(c_V_TOTAL - 1);
  localparam logic [POS_W-1:0] c_H_ACT  = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] c_V_ACT  = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] c_HS_BEG = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] c_HS_END = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] c_VS_BEG = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] c_VS_END = POS_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [POS_W-1:0] c_X0     = POS_W'(WIN_X0);
  localparam logic [POS_W-1:0] c_X1     = POS_W'(WIN_X1);
  localparam logic [POS_W-1:0] c_Y0     = POS_W'(WIN_Y0);
  localparam logic [POS_W-1:0] c_Y1     = POS_W'(WIN_Y1);

  // Inactive sync level; XOR with the internal active flag gives the pin level.
  localparam logic c_SYNC_OFF = (SYNC_POL == 0);

  localparam logic [1:0] c_MODE_NORMAL = 2'd0;
  localparam logic [1:0] c_MODE_BARS   = 2'd1;
  localparam logic [1:0] c_MODE_BORDER = 2'd2;
  localparam logic [1:0] c_MODE_RAMP   = 2'd3;

  logic [POS_W-1:0] r_hpos;
  logic [POS_W-1:0] r_vpos;

  logic             w_active;
  logic             w_inwin;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_frame_first;
  logic             w_irq_set;
  logic [3:0]       w_idx;
  logic [11:0]      w_rgb;

  // Fixed C64 palette, index to 4:4:4 RGB.
  function automatic logic [11:0] f_palette(input logic [3:0] idx);
    logic [11:0] rgb;
    rgb = 12'h000;
    case (idx)
      4'h0: rgb = 12'h000;
      4'h1: rgb = 12'hFFF;
      4'h2: rgb = 12'h833;
      4'h3: rgb = 12'h7CC;
      4'h4: rgb = 12'h848;
      4'h5: rgb = 12'h5A4;
      4'h6: rgb = 12'h339;
      4'h7: rgb = 12'hBB7;
      4'h8: rgb = 12'h852;
      4'h9: rgb = 12'h540;
      4'hA: rgb = 12'hC66;
      4'hB: rgb = 12'h444;
      4'hC: rgb = 12'h777;
      4'hD: rgb = 12'h9E8;
      4'hE: rgb = 12'h77D;
      4'hF: rgb = 12'hAAA;
    endcase
    return rgb;
  endfunction

  // Pixel/line counters: hpos wraps each line and carries into vpos.
  always_ff @(posedge clkHDMI or negedge reset) begin
    if (!reset) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (r_hpos == c_H_LAST) begin
      r_hpos <= '0;
      r_vpos <= (r_vpos == c_V_LAST) ? '0 : r_vpos + 1'b1;
    end else begin
      r_hpos <= r_hpos + 1'b1;
    end
  end

  assign o_hpos = r_hpos;
  assign o_vpos = r_vpos;

  // Timing decode and colour index selection for the current position.
  always_comb begin
    w_active      = (r_hpos < c_H_ACT) && (r_vpos < c_V_ACT);
    w_inwin       = (r_hpos >= c_X0) && (r_hpos < c_X1) &&
                    (r_vpos >= c_Y0) && (r_vpos < c_Y1);
    w_hs_act      = (r_hpos >= c_HS_BEG) && (r_hpos < c_HS_END);
    w_vs_act      = (r_vpos >= c_VS_BEG) && (r_vpos < c_VS_END);
    w_frame_first = (r_hpos == '0) && (r_vpos == '0);
    // Out-of-range compare values can never match because vpos never gets there.
    w_irq_set     = (r_hpos == '0) && (r_vpos == raster_cmp);

    w_idx = border_col;
    case (mode)
      c_MODE_NORMAL: begin
        if (w_inwin) w_idx = pix_valid ? pixel_col_in : bg_col;
        else         w_idx = border_col;
      end
      c_MODE_BARS:   w_idx = 4'(r_hpos >> 6);
      c_MODE_BORDER: w_idx = border_col;
      c_MODE_RAMP:   w_idx = r_vpos[3:0];
    endcase

    w_rgb = w_active ? f_palette(w_idx) : 12'h000;
  end

  // Single output register stage keeping syncs, enable, colour and frame pulse aligned.
  always_ff @(posedge clkHDMI or negedge reset) begin
    if (!reset) begin
      o_hsync       <= c_SYNC_OFF;
      o_vsync       <= c_SYNC_OFF;
      o_display_on  <= 1'b0;
      o_red         <= 4'h0;
      o_green       <= 4'h0;
      o_blue        <= 4'h0;
      o_frame_start <= 1'b0;
    end else begin
      o_hsync       <= w_hs_act ^ c_SYNC_OFF;
      o_vsync       <= w_vs_act ^ c_SYNC_OFF;
      o_display_on  <= w_active;
      o_red         <= w_rgb[11:8];
      o_green       <= w_rgb[7:4];
      o_blue        <= w_rgb[3:0];
      o_frame_start <= w_frame_first;
    end
  end

  // Raster IRQ latch: a new compare event takes priority over a same-cycle ack.
  always_ff @(posedge clkHDMI or negedge reset) begin
    if (!reset) begin
      o_irq <= 1'b0;
    end else if (w_irq_set) begin
      o_irq <= 1'b1;
    end else if (irq_ack) begin
      o_irq <= 1'b0;
    end
  end

endmodule
`default_nettype wire
